// File: rtl/banner_scroller_if.sv
// banner_scroller_if: row handshake from scroller to display driver.
// row_valid/row_ready transfer, row_index row number, row_pixels window (MSB leftmost).
interface banner_scroller_if #(
  parameter int WIN = 32
);
  logic           row_valid;
  logic           row_ready;
  logic [3:0]     row_index;
  logic [WIN-1:0] row_pixels;

  modport master (
    output row_valid,
    output row_index,
    output row_pixels,
    input  row_ready
  );

  modport slave (
    input  row_valid,
    input  row_index,
    input  row_pixels,
    output row_ready
  );
endinterface

// File: rtl/banner_scroller.sv
// banner_scroller: per-frame ROM row walk with wrapping horizontal window.
// Ports: clk, rst_n, start, scroll_en, rom_address/rom_data, row (if), frame_done, offset.
module banner_scroller #(
  parameter int ROWS       = 15,
  parameter int COLS       = 70,
  parameter int WIN        = 32,
  parameter int SCROLL_DIV = 4,
  parameter int OW         = $clog2(COLS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                scroll_en,
  output logic [4:0]          rom_address,
  input  logic [COLS-1:0]     rom_data,
  banner_scroller_if.master   row,
  output logic                frame_done,
  output logic [OW-1:0]       offset
);
  localparam int SW = OW + 1;
  localparam int FW = $clog2(SCROLL_DIV + 1);

  typedef logic [SW-1:0] sum_t;
  typedef logic [OW-1:0] off_t;
  typedef logic [FW-1:0] fcnt_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    EMIT
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [3:0]     row_q;
  fcnt_t          fcnt;
  logic           xfer;
  logic           last;
  logic [COLS-1:0] rev;
  logic [WIN-1:0] win;
  sum_t           col;

  assign xfer = (state == EMIT) && row.row_ready;
  assign last = (row_q == 4'(ROWS - 1));

  // rev[c] is bitmap column c; offset+j < 2*COLS so one subtract wraps it
  always_comb begin
    rev = '0;
    win = '0;
    col = '0;
    for (int c = 0; c < COLS; c++) begin
      rev[c] = rom_data[COLS-1-c];
    end
    for (int j = 0; j < WIN; j++) begin
      col = sum_t'(offset) + sum_t'(j);
      if (col >= sum_t'(COLS)) begin
        col = col - sum_t'(COLS);
      end
      win[WIN-1-j] = rev[col[OW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = FETCH;
      FETCH:   state_n = WAIT;
      WAIT:    state_n = EMIT;
      EMIT:    if (xfer) state_n = last ? IDLE : FETCH;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_address    <= '0;
      row.row_valid  <= 1'b0;
      row.row_index  <= '0;
      row.row_pixels <= '0;
      frame_done     <= 1'b0;
      offset         <= '0;
      row_q          <= '0;
      fcnt           <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (1'b1)
        (state == IDLE) && start: begin
          row_q       <= '0;
          rom_address <= '0;
        end
        state == WAIT: begin
          row.row_pixels <= win;
          row.row_index  <= row_q;
          row.row_valid  <= 1'b1;
        end
        xfer && !last: begin
          row.row_valid <= 1'b0;
          row_q         <= row_q + 4'd1;
          rom_address   <= {1'b0, row_q + 4'd1};
        end
        xfer && last: begin
          row.row_valid <= 1'b0;
          frame_done    <= 1'b1;
          // offset only moves here, so a frame never mixes offsets
          if (scroll_en) begin
            if (fcnt == fcnt_t'(SCROLL_DIV - 1)) begin
              fcnt   <= '0;
              offset <= (offset == off_t'(COLS - 1)) ?
                        '0 : offset + off_t'(1);
            end else begin
              fcnt <= fcnt + fcnt_t'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_banner_scroller.sv
// tb_banner_scroller: directed bench for banner_scroller (SCROLL_DIV=2).
// Models the registered banner ROM and checks rows, timing, scroll and reset.
module tb_banner_scroller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        scroll_en = 1'b0;
  logic [4:0]  rom_address;
  logic [69:0] rom_data;
  logic        frame_done;
  logic [6:0]  offset;

  banner_scroller_if #(.WIN(32)) rif ();

  banner_scroller #(
    .ROWS(15),
    .COLS(70),
    .WIN(32),
    .SCROLL_DIV(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .scroll_en(scroll_en),
    .rom_address(rom_address),
    .rom_data(rom_data),
    .row(rif),
    .frame_done(frame_done),
    .offset(offset)
  );

  logic [69:0] rom_mem [15];
  logic [69:0] base;
  logic [31:0] p0;
  int nvec = 0;
  int nerr = 0;
  int exp_off = 0;
  int exp_cnt = 0;
  int t4_exp [5] = '{0, 1, 1, 2, 2};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data <= (rom_address < 5'd15) ?
                rom_mem[rom_address[3:0]] : '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] win_f(input logic [69:0] d,
                                        input int off);
    logic [31:0] w;
    int c;
    w = '0;
    for (int j = 0; j < 32; j++) begin
      c = (off + j) % 70;
      w[31-j] = d[69-c];
    end
    return w;
  endfunction

  task automatic chk_reset();
    chk("rst_addr", 32'(rom_address), 32'd0);
    chk("rst_valid", 32'(rif.row_valid), 32'd0);
    chk("rst_index", 32'(rif.row_index), 32'd0);
    chk("rst_pixels", rif.row_pixels, 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_offset", 32'(offset), 32'd0);
  endtask

  task automatic do_frame(input bit chk_pix,
                          input bit hold,
                          input int stall_row,
                          input int rst_row);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    for (int r = 0; r < 15; r++) begin
      chk("fetch_addr", 32'(rom_address), 32'(r));
      tick();
      chk("wait_valid", 32'(rif.row_valid), 32'd0);
      chk("wait_addr", 32'(rom_address), 32'(r));
      tick();
      chk("emit_valid", 32'(rif.row_valid), 32'd1);
      chk("emit_index", 32'(rif.row_index), 32'(r));
      if (chk_pix) begin
        chk("emit_pixels", rif.row_pixels,
            win_f(rom_mem[r], exp_off));
      end
      if (r == 0) p0 = rif.row_pixels;
      if (r == rst_row) begin
        #2 rst_n = 1'b0;
        #1 chk_reset();
        tick();
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        exp_off = 0;
        exp_cnt = 0;
        return;
      end
      if (r == stall_row) begin
        rif.row_ready = 1'b0;
        repeat (5) begin
          tick();
          chk("stall_valid", 32'(rif.row_valid), 32'd1);
          chk("stall_index", 32'(rif.row_index), 32'(r));
          chk("stall_pixels", rif.row_pixels,
              win_f(rom_mem[r], exp_off));
          chk("stall_addr", 32'(rom_address), 32'(r));
        end
        rif.row_ready = 1'b1;
      end
      tick();
    end
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    if (scroll_en) begin
      exp_cnt++;
      if (exp_cnt == 2) begin
        exp_cnt = 0;
        exp_off = (exp_off == 69) ? 0 : exp_off + 1;
      end
    end
    chk("offset", 32'(offset), 32'(exp_off));
    if (!hold) begin
      tick();
      chk("frame_done_low", 32'(frame_done), 32'd0);
    end
  endtask

  initial begin
    for (int c = 0; c < 70; c++) begin
      base[69-c] = (c < 6) || (c >= 12 && c < 18) ||
                   (c >= 24 && c < 32) || (c == 69);
    end
    for (int r = 0; r < 15; r++) begin
      rom_mem[r] = base ^ (70'(r) << 40);
    end
    rif.row_ready = 1'b1;

    repeat (2) tick();
    chk_reset();
    rst_n = 1'b1;
    tick();
    chk_reset();

    // T1: offset 0, full frame with exact timing
    scroll_en = 1'b0;
    do_frame(1'b1, 1'b0, -1, -1);
    chk("t1_row0", p0, 32'hFC0FC0FF);
    tick();
    chk("idle_valid", 32'(rif.row_valid), 32'd0);

    // T4: divide-by-2 scroll
    scroll_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_frame(1'b0, 1'b0, -1, -1);
      chk("t4_offset", 32'(offset), 32'(t4_exp[i]));
    end
    scroll_en = 1'b0;
    do_frame(1'b0, 1'b0, -1, -1);
    chk("t4_frozen", 32'(offset), 32'd2);

    // T2: walk to offset 60, then check wrapped window
    scroll_en = 1'b1;
    for (int i = 0; i < 200 && exp_off != 60; i++) begin
      do_frame(1'b0, 1'b0, -1, -1);
    end
    chk("t2_reach60", 32'(offset), 32'd60);
    scroll_en = 1'b0;
    do_frame(1'b1, 1'b0, -1, -1);
    chk("t2_row0", p0, 32'h007F03F0);

    // T4: wrap 69 -> 0
    scroll_en = 1'b1;
    for (int i = 0; i < 40 && exp_off != 69; i++) begin
      do_frame(1'b0, 1'b0, -1, -1);
    end
    do_frame(1'b0, 1'b0, -1, -1);
    chk("t4_at69", 32'(offset), 32'd69);
    do_frame(1'b0, 1'b0, -1, -1);
    chk("t4_wrap", 32'(offset), 32'd0);

    // T3: consumer stall on row 3
    do_frame(1'b1, 1'b0, 3, -1);
    do_frame(1'b1, 1'b0, -1, -1);
    chk("t3_offset", 32'(offset), 32'd1);

    // T5: async reset during EMIT of row 7
    do_frame(1'b1, 1'b0, -1, 7);
    chk("t5_offset", 32'(offset), 32'd0);
    chk("t5_valid", 32'(rif.row_valid), 32'd0);
    do_frame(1'b1, 1'b0, -1, -1);
    chk("t5_row0", p0, 32'hFC0FC0FF);

    // T6: start held, back-to-back frames, second uses new offset
    do_frame(1'b1, 1'b1, -1, -1);
    chk("t6_mid_offset", 32'(offset), 32'd1);
    do_frame(1'b1, 1'b1, -1, -1);
    start = 1'b0;
    tick();
    chk("t6_done_low", 32'(frame_done), 32'd0);
    chk("t6_idle_valid", 32'(rif.row_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
